// File: rtl/ysyx_22040365_ifu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040365_ifu_if
// Brief    : Bundle of the fetch-stage handshakes: memory request/response,
//            instruction hand-off to decode, and the redirect from execute.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22040365_ifu_if #(
    parameter int XLEN = 64
);
    // Memory request channel (one outstanding request at most)
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;

    // Memory response channel (one pulse per accepted request)
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    // Instruction hand-off to decode
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    // Control-flow redirect from execute
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Fetch-stage side
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    // Environment side: memory, decode and execute
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040365_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040365_ifu
// Brief    : Instruction fetch unit. Holds the PC, issues one 32-bit fetch at
//            a time, hands the instruction and its PC to decode, and follows
//            redirects from execute while discarding stale fetch data.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040365_ifu #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ysyx_22040365_ifu_if.master bus
);

    // Encoding of addi x0,x0,0 shown to decode while nothing was fetched
    localparam logic [31:0]     c_nop_inst = 32'h0000_0013;
    localparam logic [XLEN-1:0] c_pc_step  = XLEN'(4);

    // Fetch sequencing:
    //   IDLE - one settling cycle after reset
    //   REQ  - request presented to memory
    //   WAIT - request accepted, waiting for the response pulse
    //   HOLD - instruction presented to decode until consumed or redirected
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst_pc;
    logic [31:0]     r_inst;
    logic            r_kill;
    logic            r_req_valid;
    logic            r_inst_valid;

    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pc_next_seq;
    logic            w_unused_redirect_lsb;

    // Redirect targets are forced onto a word boundary; the low bits are
    // deliberately discarded.
    assign w_redirect_pc         = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // Sequential successor, wrapping modulo 2^XLEN
    assign w_pc_next_seq = r_pc + c_pc_step;

    // Fetch state machine with registered handshake outputs. The valid flags
    // are updated together with every state change so they always mirror the
    // state that is being entered, never the current inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_inst       <= c_nop_inst;
            r_inst_pc    <= '0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A response arriving here belongs to a request abandoned
                    // by reset and is ignored.
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    r_state     <= ST_REQ;
                    r_req_valid <= 1'b1;
                end

                ST_REQ: begin
                    // A redirect always moves the PC. If memory takes the
                    // request in the same cycle it was issued with the old PC,
                    // so its response must be discarded.
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (bus.req_ready) begin
                        r_state     <= ST_WAIT;
                        r_req_valid <= 1'b0;
                        if (bus.redirect_valid) begin
                            r_kill <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (bus.redirect_valid) begin
                        r_pc   <= w_redirect_pc;
                        r_kill <= 1'b1;
                    end
                    if (bus.rsp_valid) begin
                        if (r_kill || bus.redirect_valid) begin
                            // Stale data: drop it and fetch from the new PC.
                            // This clear overrides the set above.
                            r_kill      <= 1'b0;
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_inst       <= bus.rsp_data;
                            r_inst_pc    <= r_pc;
                            r_state      <= ST_HOLD;
                            r_inst_valid <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    // A redirect wins over consumption: the held instruction
                    // is on the wrong path.
                    if (bus.redirect_valid) begin
                        r_pc         <= w_redirect_pc;
                        r_state      <= ST_REQ;
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= 1'b1;
                    end else if (bus.inst_ready) begin
                        r_pc         <= w_pc_next_seq;
                        r_state      <= ST_REQ;
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_kill       <= 1'b0;
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    // The request address is the PC itself; it only changes in REQ on a
    // redirect, which keeps a stalled request stable.
    assign bus.req_valid  = r_req_valid;
    assign bus.req_addr   = r_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;

endmodule
`default_nettype wire
